// File: rtl/pwm_cfg_seq_if.sv
// Configuration handshake bundle between a register front end (master)
// and the pwm_cfg_seq sequencer (slave).
interface pwm_cfg_seq_if #(
    parameter int CNT_W = 32
);
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [2:0]       cfg_enable_i;
    logic [CNT_W-1:0] cfg_prescaler_i;
    logic [CNT_W-1:0] cfg_period_i;
    logic [CNT_W-1:0] cfg_duty_i;
    logic [CNT_W-1:0] cfg_step_i;

    modport master (
        output cfg_valid_i, cfg_enable_i, cfg_prescaler_i, cfg_period_i,
               cfg_duty_i, cfg_step_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_enable_i, cfg_prescaler_i, cfg_period_i,
               cfg_duty_i, cfg_step_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/pwm_cfg_seq.sv
// Glitch-free PWM configuration sequencer: shadows a new configuration and
// applies it on PWM period boundaries, optionally ramping the duty cycle.
module pwm_cfg_seq #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    pwm_cfg_seq_if.slave     cfg,
    input  logic             period_end_i,
    output logic [2:0]       enable_o,
    output logic [CNT_W-1:0] prescaler_o,
    output logic [CNT_W-1:0] pwm_period_o,
    output logic [CNT_W-1:0] duty_cycle_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, RAMP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sh_enable_q, sh_enable_d;
    logic [CNT_W-1:0] sh_prescaler_q, sh_prescaler_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_target_q, sh_target_d;
    logic [CNT_W-1:0] sh_step_q, sh_step_d;
    logic [2:0]       enable_d;
    logic [CNT_W-1:0] prescaler_d, pwm_period_d, duty_cycle_d;
    logic             done_d, err_d;

    // Ramp distance is computed one bit wider so duty +/- step can never wrap.
    logic [CNT_W:0] duty_w, target_w, step_w, dist_w;

    assign duty_w   = {1'b0, duty_cycle_o};
    assign target_w = {1'b0, sh_target_q};
    assign step_w   = {1'b0, sh_step_q};
    assign dist_w   = (target_w > duty_w) ? (target_w - duty_w) : (duty_w - target_w);

    assign cfg.cfg_ready_o = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // paths that do not assign it cannot infer a latch.
        state_d        = state_q;
        sh_enable_d    = sh_enable_q;
        sh_prescaler_d = sh_prescaler_q;
        sh_period_d    = sh_period_q;
        sh_target_d    = sh_target_q;
        sh_step_d      = sh_step_q;
        enable_d       = enable_o;
        prescaler_d    = prescaler_o;
        pwm_period_d   = pwm_period_o;
        duty_cycle_d   = duty_cycle_o;
        done_d         = 1'b0;
        err_d          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg.cfg_valid_i) begin
                    if (cfg.cfg_period_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        sh_enable_d    = cfg.cfg_enable_i;
                        sh_prescaler_d = cfg.cfg_prescaler_i;
                        sh_period_d    = cfg.cfg_period_i;
                        sh_target_d    = (cfg.cfg_duty_i > cfg.cfg_period_i) ?
                                         cfg.cfg_period_i : cfg.cfg_duty_i;
                        sh_step_d      = cfg.cfg_step_i;
                        state_d        = WAIT_EDGE;
                    end
                end
            end
            WAIT_EDGE: begin
                if (period_end_i) begin
                    enable_d     = sh_enable_q;
                    prescaler_d  = sh_prescaler_q;
                    pwm_period_d = sh_period_q;
                    // A stopped channel or zero step has nothing to ramp from.
                    if (sh_step_q == '0 || enable_o == '0 || sh_enable_q == '0) begin
                        duty_cycle_d = sh_target_q;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        duty_cycle_d = (duty_cycle_o > sh_period_q) ? sh_period_q : duty_cycle_o;
                        state_d      = RAMP;
                    end
                end
            end
            RAMP: begin
                if (period_end_i) begin
                    if (dist_w <= step_w) begin
                        duty_cycle_d = sh_target_q;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else if (target_w > duty_w) begin
                        duty_cycle_d = duty_cycle_o + sh_step_q;
                    end else begin
                        duty_cycle_d = duty_cycle_o - sh_step_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: shadow registers are cleared too, so a configuration pending
            // at reset can never leak into a later apply.
            state_q        <= IDLE;
            sh_enable_q    <= '0;
            sh_prescaler_q <= '0;
            sh_period_q    <= '0;
            sh_target_q    <= '0;
            sh_step_q      <= '0;
            enable_o       <= '0;
            prescaler_o    <= '0;
            pwm_period_o   <= '0;
            duty_cycle_o   <= '0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers sampling the
            // same pre-edge values, independent of statement order.
            state_q        <= state_d;
            sh_enable_q    <= sh_enable_d;
            sh_prescaler_q <= sh_prescaler_d;
            sh_period_q    <= sh_period_d;
            sh_target_q    <= sh_target_d;
            sh_step_q      <= sh_step_d;
            enable_o       <= enable_d;
            prescaler_o    <= prescaler_d;
            pwm_period_o   <= pwm_period_d;
            duty_cycle_o   <= duty_cycle_d;
            done_o         <= done_d;
            err_o          <= err_d;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_seq.sv
// Directed self-checking bench for pwm_cfg_seq: immediate apply, ramps up and
// down, rejected configs, ignored offers while busy, and asynchronous reset.
module tb_pwm_cfg_seq;

    localparam int CNT_W = 32;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             period_end_i = 1'b0;
    logic [2:0]       enable_o;
    logic [CNT_W-1:0] prescaler_o, pwm_period_o, duty_cycle_o;
    logic             busy_o, done_o, err_o;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_cfg_seq_if #(.CNT_W(CNT_W)) cfg_bus ();

    pwm_cfg_seq #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg         (cfg_bus.slave),
        .period_end_i(period_end_i),
        .enable_o    (enable_o),
        .prescaler_o (prescaler_o),
        .pwm_period_o(pwm_period_o),
        .duty_cycle_o(duty_cycle_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_pe();
        period_end_i = 1'b1;
        tick();
        period_end_i = 1'b0;
    endtask

    task automatic offer_cfg(input logic [2:0] en, input int presc, input int per,
                             input int duty, input int step, input logic with_pe);
        cfg_bus.cfg_valid_i     = 1'b1;
        cfg_bus.cfg_enable_i    = en;
        cfg_bus.cfg_prescaler_i = presc;
        cfg_bus.cfg_period_i    = per;
        cfg_bus.cfg_duty_i      = duty;
        cfg_bus.cfg_step_i      = step;
        period_end_i            = with_pe;
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
        period_end_i        = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int en, input int presc,
                              input int per, input int duty);
        check({tag, ".en"},    32'(enable_o),   en);
        check({tag, ".presc"}, prescaler_o,     presc);
        check({tag, ".per"},   pwm_period_o,    per);
        check({tag, ".duty"},  duty_cycle_o,    duty);
    endtask

    initial begin
        cfg_bus.cfg_valid_i     = 1'b0;
        cfg_bus.cfg_enable_i    = '0;
        cfg_bus.cfg_prescaler_i = '0;
        cfg_bus.cfg_period_i    = '0;
        cfg_bus.cfg_duty_i      = '0;
        cfg_bus.cfg_step_i      = '0;
        #12;
        check_outs("rst", 0, 0, 0, 0);
        check("rst.ready", 32'(cfg_bus.cfg_ready_o), 1);
        check("rst.busy", 32'(busy_o), 0);
        check("rst.done", 32'(done_o), 0);
        check("rst.err", 32'(err_o), 0);
        rstn_i = 1'b1;
        tick();

        // Immediate apply, edge 3 cycles after capture.
        offer_cfg(3'b111, 4, 100, 40, 0, 1'b0);
        check("imm.busy", 32'(busy_o), 1);
        check("imm.ready", 32'(cfg_bus.cfg_ready_o), 0);
        tick();
        tick();
        check_outs("imm.hold", 0, 0, 0, 0);
        pulse_pe();
        check_outs("imm.apply", 7, 4, 100, 40);
        check("imm.done", 32'(done_o), 1);
        check("imm.idle", 32'(busy_o), 0);
        tick();
        check("imm.done_off", 32'(done_o), 0);

        // Ramp up 10 -> 40 by 10; pulse coincident with capture is ignored.
        offer_cfg(3'b111, 4, 100, 10, 0, 1'b0);
        pulse_pe();
        check("up.pre", duty_cycle_o, 10);
        offer_cfg(3'b111, 4, 100, 40, 10, 1'b1);
        check("up.coinc_busy", 32'(busy_o), 1);
        check("up.coinc_duty", duty_cycle_o, 10);
        pulse_pe();
        check("up.apply", duty_cycle_o, 10);
        check("up.ramp_busy", 32'(busy_o), 1);
        pulse_pe();
        check("up.s1", duty_cycle_o, 20);
        check("up.s1_done", 32'(done_o), 0);
        offer_cfg(3'b001, 1, 0, 0, 0, 1'b0);
        check("up.busy_ignore_err", 32'(err_o), 0);
        check("up.busy_ignore_ready", 32'(cfg_bus.cfg_ready_o), 0);
        tick();
        check_outs("up.hold", 7, 4, 100, 20);
        pulse_pe();
        check("up.s2", duty_cycle_o, 30);
        pulse_pe();
        check("up.s3", duty_cycle_o, 40);
        check("up.done", 32'(done_o), 1);
        tick();
        check("up.done_off", 32'(done_o), 0);

        // Ramp down 50 -> 5 by 20, final step lands exactly on target.
        offer_cfg(3'b111, 4, 100, 50, 0, 1'b0);
        pulse_pe();
        offer_cfg(3'b111, 4, 100, 5, 20, 1'b0);
        pulse_pe();
        check("dn.apply", duty_cycle_o, 50);
        pulse_pe();
        check("dn.s1", duty_cycle_o, 30);
        pulse_pe();
        check("dn.s2", duty_cycle_o, 10);
        check("dn.s2_done", 32'(done_o), 0);
        pulse_pe();
        check("dn.s3", duty_cycle_o, 5);
        check("dn.done", 32'(done_o), 1);
        tick();

        // Zero period rejected; then oversized duty clamped to period.
        offer_cfg(3'b011, 9, 0, 30, 0, 1'b0);
        check("err.pulse", 32'(err_o), 1);
        check("err.no_done", 32'(done_o), 0);
        check("err.idle", 32'(busy_o), 0);
        check_outs("err.outs", 7, 4, 100, 5);
        tick();
        check("err.off", 32'(err_o), 0);
        offer_cfg(3'b111, 4, 60, 90, 0, 1'b0);
        pulse_pe();
        check("clamp.duty", duty_cycle_o, 60);
        check("clamp.per", pwm_period_o, 60);
        tick();

        // Asynchronous reset in the middle of a ramp.
        offer_cfg(3'b111, 4, 60, 40, 5, 1'b0);
        pulse_pe();
        pulse_pe();
        check("rr.s1", duty_cycle_o, 55);
        rstn_i = 1'b0;
        #1;
        check_outs("rr.async", 0, 0, 0, 0);
        check("rr.busy", 32'(busy_o), 0);
        #5;
        rstn_i = 1'b1;
        tick();
        check("rr.ready", 32'(cfg_bus.cfg_ready_o), 1);
        pulse_pe();
        check_outs("rr.discard", 0, 0, 0, 0);
        check("rr.no_done", 32'(done_o), 0);

        // From disabled outputs a nonzero step still applies immediately.
        offer_cfg(3'b111, 2, 100, 30, 10, 1'b0);
        pulse_pe();
        check_outs("off.imm", 7, 2, 100, 30);
        check("off.done", 32'(done_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_cfg_seq.md
PWM_CFG_SEQ -- requirements
Module: pwm_cfg_seq

Interface
REQ-001 Parameter: CNT_W, 32, width of prescaler, period, duty and ramp-step fields.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 cfg_valid_i  input  1  new configuration offered.
REQ-005 cfg_ready_o  output  1  configuration accepted when high with cfg_valid_i.
REQ-006 cfg_enable_i  input  3  requested channel enables.
REQ-007 cfg_prescaler_i  input  CNT_W  requested prescaler.
REQ-008 cfg_period_i  input  CNT_W  requested PWM period.
REQ-009 cfg_duty_i  input  CNT_W  requested target duty cycle.
REQ-010 cfg_step_i  input  CNT_W  duty ramp step per PWM period; 0 = immediate.
REQ-011 period_end_i  input  1  single-cycle pulse from the PWM core at period wrap.
REQ-012 enable_o  output  3  channel enables to the PWM core.
REQ-013 prescaler_o  output  CNT_W  prescaler to the PWM core.
REQ-014 pwm_period_o  output  CNT_W  period to the PWM core.
REQ-015 duty_cycle_o  output  CNT_W  duty cycle to the PWM core.
REQ-016 busy_o  output  1  high when not IDLE.
REQ-017 done_o  output  1  one-cycle pulse when the target configuration is fully applied.
REQ-018 err_o  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-019 FSM states: IDLE, WAIT_EDGE, RAMP; all outputs registered except cfg_ready_o (= state==IDLE) and busy_o (= state!=IDLE).
REQ-020 IDLE, cfg_valid_i=1, cfg_period_i=0: err_o pulses next cycle, nothing captured, stay IDLE.
REQ-021 IDLE, cfg_valid_i=1, cfg_period_i!=0: capture all cfg_* into shadow registers, target duty clamped to min(cfg_duty_i, cfg_period_i), go WAIT_EDGE.
REQ-022 cfg_valid_i outside IDLE: ignored, no capture, no err_o.
REQ-023 period_end_i in IDLE: ignored; period_end_i coincident with capture: ignored, application waits for next pulse.
REQ-024 WAIT_EDGE, period_end_i=1: on that edge load enable_o, prescaler_o, pwm_period_o from shadow simultaneously.
REQ-025 Same edge, immediate case (shadow step=0, or current enable_o==0, or shadow enable==0): duty_cycle_o <= target, done_o pulses next cycle, go IDLE.
REQ-026 Otherwise same edge: duty_cycle_o <= min(duty_cycle_o, shadow period) (clamp only), go RAMP.
REQ-027 RAMP, period_end_i=1: if |target - duty_cycle_o| <= step then duty_cycle_o <= target, done_o pulse, go IDLE; else duty_cycle_o moves by exactly step toward target.
REQ-028 Ramp arithmetic on CNT_W+1 bits; duty_cycle_o never wraps, never passes target, never exceeds pwm_period_o.
REQ-029 RAMP without period_end_i: all outputs hold.
REQ-030 done_o and err_o never both high; each high exactly one cycle per event.
REQ-031 Outputs only change on period_end_i edges (except reset), so the PWM core never sees a mid-period update.

Reset
REQ-032 rstn_i low: state IDLE, enable_o=0, prescaler_o=0, pwm_period_o=0, duty_cycle_o=0, done_o=0, err_o=0, shadow registers 0; cfg_ready_o=1, busy_o=0.
REQ-033 Reset asserted mid-WAIT_EDGE or mid-RAMP: pending configuration discarded, outputs take reset values immediately without waiting for a clock.

Verification
REQ-034 From reset, cfg {en=3'b111, presc=4, period=100, duty=40, step=0}, period_end_i 3 cycles later -> outputs unchanged until that edge, then en=7, presc=4, period=100, duty=40, done_o one pulse next cycle.
REQ-035 Outputs en=7, period=100, duty=10; cfg {en=7, period=100, duty=40, step=10} -> duty 10 at apply, then 20, 30, 40 on successive period_end_i pulses, done_o with 40.
REQ-036 Ramp down: duty=50, cfg {duty=5, step=20, period=100} -> 50, 30, 10, 5, done_o at 5 (no undershoot).
REQ-037 cfg {period=0} -> err_o single pulse, outputs and state unchanged; cfg {period=60, duty=90, step=0} -> duty_cycle_o=60 after edge.
REQ-038 Second cfg_valid_i during RAMP -> cfg_ready_o=0, ignored; rstn_i low mid-RAMP -> all outputs 0 asynchronously, cfg_ready_o=1 after release.
